// File: rtl/move_tx.sv
// move_tx: validates a 1- or 2-stone Connect6 move and serialises it as a checksummed byte frame
// on a valid/ready stream. Define MOVE_TX_SEQ_EN to insert an 8-bit frame sequence byte after SYNC.
module move_tx #(
   parameter int         BOARD_SIZE = 19,
   parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       move_valid,
   output logic       move_ready,
   input  logic [1:0] stone_count,
   input  logic [5:0] x_1,
   input  logic [5:0] y_1,
   input  logic [5:0] x_2,
   input  logic [5:0] y_2,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   output logic       busy,
   output logic       err_move
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SYNC,
      S_SEQ,
      S_COUNT,
      S_COORD,
      S_CSUM
   } state_t;

   localparam logic [5:0] LIMIT = 6'(BOARD_SIZE);

   state_t     state_q, state_d;
   logic [1:0] cnt_q;
   logic [5:0] x1_q, y1_q, x2_q, y2_q;
   logic [1:0] idx_q;
   logic [1:0] idx_last;
   logic [7:0] csum_q;
   logic [7:0] coord_byte;
   logic       err_q;
   logic       accept;
   logic       xfer;
   logic       move_good;
`ifdef MOVE_TX_SEQ_EN
   logic [7:0] seq_q;
`endif

   // Second-stone fields only matter for a 2-stone move.
   function automatic logic move_ok(input logic [1:0] cnt,
                                    input logic [5:0] xa, input logic [5:0] ya,
                                    input logic [5:0] xb, input logic [5:0] yb);
      logic ok;
      ok = ((cnt == 2'd1) || (cnt == 2'd2)) && (xa < LIMIT) && (ya < LIMIT);
      if (cnt == 2'd2)
         ok = ok && (xb < LIMIT) && (yb < LIMIT) && !((xa == xb) && (ya == yb));
      return ok;
   endfunction

   assign accept    = move_valid && move_ready;
   assign xfer      = tx_valid && tx_ready;
   assign move_good = move_ok(stone_count, x_1, y_1, x_2, y_2);
   assign idx_last  = (cnt_q == 2'd2) ? 2'd3 : 2'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept && move_good) state_d = S_SYNC;
`ifdef MOVE_TX_SEQ_EN
         S_SYNC:  if (xfer) state_d = S_SEQ;
         S_SEQ:   if (xfer) state_d = S_COUNT;
`else
         S_SYNC:  if (xfer) state_d = S_COUNT;
`endif
         S_COUNT: if (xfer) state_d = S_COORD;
         S_COORD: if (xfer && (idx_q == idx_last)) state_d = S_CSUM;
         S_CSUM:  if (xfer) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      case (idx_q)
         2'd0:    coord_byte = {2'b00, x1_q};
         2'd1:    coord_byte = {2'b00, y1_q};
         2'd2:    coord_byte = {2'b00, x2_q};
         default: coord_byte = {2'b00, y2_q};
      endcase
   end

   // tx_data is a pure function of registered state, so it holds while stalled.
   always_comb begin
      move_ready = (state_q == S_IDLE);
      busy       = (state_q != S_IDLE);
      tx_valid   = (state_q != S_IDLE);
      err_move   = err_q;
      case (state_q)
         S_SYNC:  tx_data = SYNC_BYTE;
`ifdef MOVE_TX_SEQ_EN
         S_SEQ:   tx_data = seq_q;
`endif
         S_COUNT: tx_data = {6'b0, cnt_q};
         S_COORD: tx_data = coord_byte;
         S_CSUM:  tx_data = csum_q;
         default: tx_data = 8'h00;
      endcase
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         cnt_q <= stone_count;
         x1_q  <= x_1;
         y1_q  <= y_1;
         x2_q  <= x_2;
         y2_q  <= y_2;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q  <= 1'b0;
         idx_q  <= 2'd0;
         csum_q <= 8'h00;
      end else begin
         err_q <= accept && !move_good;
         if (accept) begin
            idx_q  <= 2'd0;
            csum_q <= 8'h00;
         end else if (xfer) begin
            if (state_q == S_COORD)
               idx_q <= idx_q + 2'd1;
            if ((state_q == S_SEQ) || (state_q == S_COUNT) || (state_q == S_COORD))
               csum_q <= csum_q ^ tx_data;
         end
      end
   end

`ifdef MOVE_TX_SEQ_EN
   // Counts completed frames only; wraps naturally at 8 bits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                             seq_q <= 8'h00;
      else if (xfer && (state_q == S_CSUM)) seq_q <= seq_q + 8'h01;
   end
`endif

endmodule

// File: tb/tb_move_tx.sv
// Directed bench for move_tx: frame bytes, stalls, rejected moves, mid-frame reset, back-to-back frames.
`timescale 1ns/1ps
module tb_move_tx;

   logic       clk = 1'b0;
   logic       rst;
   logic       move_valid;
   logic       move_ready;
   logic [1:0] stone_count;
   logic [5:0] x_1, y_1, x_2, y_2;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       busy;
   logic       err_move;

   int         n_tests = 0;
   int         n_fail  = 0;
   logic [7:0] exp_q [8];
   int         exp_n;
   logic [7:0] seq_m = 8'h00;

   move_tx dut (
      .clk        (clk),
      .rst        (rst),
      .move_valid (move_valid),
      .move_ready (move_ready),
      .stone_count(stone_count),
      .x_1        (x_1),
      .y_1        (y_1),
      .x_2        (x_2),
      .y_2        (y_2),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .busy       (busy),
      .err_move   (err_move)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Expected frame from the hand-written base bytes; the SEQ byte is spliced in when enabled.
   task automatic set_exp(input int n, input logic [55:0] bytes);
      logic [7:0] core [7];
      for (int i = 0; i < n; i++) core[i] = bytes[55-8*i -: 8];
`ifdef MOVE_TX_SEQ_EN
      exp_q[0] = core[0];
      exp_q[1] = seq_m;
      for (int i = 1; i < n; i++) exp_q[i+1] = core[i];
      exp_q[n] = exp_q[n] ^ seq_m;
      exp_n = n + 1;
`else
      for (int i = 0; i < n; i++) exp_q[i] = core[i];
      exp_n = n;
`endif
   endtask

   task automatic present(input logic [1:0] cnt, input logic [5:0] xa, input logic [5:0] ya,
                          input logic [5:0] xb, input logic [5:0] yb);
      stone_count = cnt;
      x_1 = xa; y_1 = ya; x_2 = xb; y_2 = yb;
      move_valid = 1'b1;
   endtask

   task automatic send_move(input logic [1:0] cnt, input logic [5:0] xa, input logic [5:0] ya,
                            input logic [5:0] xb, input logic [5:0] yb);
      present(cnt, xa, ya, xb, yb);
      check("ready_before_accept", move_ready, 1);
      step();
      move_valid = 1'b0;
   endtask

   // Called in the cycle after acceptance; consumes the expected frame.
   task automatic run_frame(input bit toggle);
      int got = 0;
      int cyc = 0;
      while (got < exp_n && cyc < 200) begin
         tx_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
         check("tx_valid_in_frame", tx_valid, 1);
         check("busy_in_frame", busy, 1);
         check("move_ready_in_frame", move_ready, 0);
         check($sformatf("byte%0d", got), tx_data, exp_q[got]);
         if (tx_ready) got++;
         step();
         cyc++;
      end
      if (cyc >= 200) check("frame_timeout", 0, 1);
      tx_ready = 1'b1;
      check("tx_valid_end", tx_valid, 0);
      check("move_ready_end", move_ready, 1);
      check("busy_end", busy, 0);
`ifdef MOVE_TX_SEQ_EN
      seq_m = seq_m + 8'h01;
`endif
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      #1;
      check("rst_move_ready", move_ready, 1);
      check("rst_tx_valid", tx_valid, 0);
      check("rst_tx_data", tx_data, 8'h00);
      check("rst_busy", busy, 0);
      check("rst_err_move", err_move, 0);
      step();
      rst = 1'b0;
      seq_m = 8'h00;
      step();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; move_valid = 1'b0; tx_ready = 1'b1;
      stone_count = 2'd0; x_1 = 6'd0; y_1 = 6'd0; x_2 = 6'd0; y_2 = 6'd0;
      step();
      apply_reset();

      // Two stones, no stall
      set_exp(7, {8'hA5, 8'h02, 8'h03, 8'h04, 8'h11, 8'h00, 8'h14});
      send_move(2'd2, 6'd3, 6'd4, 6'd17, 6'd0);
      run_frame(1'b0);

      // One stone, alternating ready
      set_exp(5, {8'hA5, 8'h01, 8'h09, 8'h09, 8'h01, 16'h0});
      send_move(2'd1, 6'd9, 6'd9, 6'd0, 6'd0);
      run_frame(1'b1);

      // Rejected moves
      send_move(2'd2, 6'd19, 6'd2, 6'd0, 6'd0);
      check("err_range", err_move, 1);
      check("err_range_novalid", tx_valid, 0);
      step();
      check("err_range_clear", err_move, 0);
      send_move(2'd3, 6'd1, 6'd1, 6'd2, 6'd2);
      check("err_count", err_move, 1);
      check("err_count_novalid", tx_valid, 0);
      step();
      check("err_count_clear", err_move, 0);
      send_move(2'd2, 6'd5, 6'd5, 6'd5, 6'd5);
      check("err_dup", err_move, 1);
      check("err_dup_novalid", tx_valid, 0);
      step();
      check("err_dup_clear", err_move, 0);
      check("err_dup_idle", tx_valid, 0);
      check("err_dup_ready", move_ready, 1);

      // Second-stone fields ignored for a 1-stone move; y_1 = 18 is the top legal value
      set_exp(5, {8'hA5, 8'h01, 8'h00, 8'h12, 8'h13, 16'h0});
      send_move(2'd1, 6'd0, 6'd18, 6'd63, 6'd63);
      check("edge_no_err", err_move, 0);
      run_frame(1'b0);

      // Reset during COORD
      send_move(2'd2, 6'd3, 6'd4, 6'd17, 6'd0);
      tx_ready = 1'b1;
`ifdef MOVE_TX_SEQ_EN
      repeat (4) step();
`else
      repeat (3) step();
`endif
      check("pre_rst_coord_valid", tx_valid, 1);
      check("pre_rst_coord_data", tx_data, 8'h04);
      rst = 1'b1;
      #1;
      check("midrst_tx_valid", tx_valid, 0);
      check("midrst_move_ready", move_ready, 1);
      check("midrst_busy", busy, 0);
      check("midrst_tx_data", tx_data, 8'h00);
      step();
      rst = 1'b0;
      seq_m = 8'h00;
      step();
      check("post_rst_idle", tx_valid, 0);
      set_exp(5, {8'hA5, 8'h01, 8'h00, 8'h00, 8'h01, 16'h0});
      send_move(2'd1, 6'd0, 6'd0, 6'd0, 6'd0);
      run_frame(1'b0);

      // Back-to-back with move_valid held: one idle cycle between frames
      set_exp(5, {8'hA5, 8'h01, 8'h07, 8'h02, 8'h04, 16'h0});
      present(2'd1, 6'd7, 6'd2, 6'd0, 6'd0);
      step();
      run_frame(1'b0);
      step();
      move_valid = 1'b0;
      set_exp(5, {8'hA5, 8'h01, 8'h07, 8'h02, 8'h04, 16'h0});
      check("b2b_sync_valid", tx_valid, 1);
      run_frame(1'b0);

`ifdef MOVE_TX_SEQ_EN
      apply_reset();
      for (int f = 0; f < 257; f++) begin
         set_exp(5, {8'hA5, 8'h01, 8'h00, 8'h00, 8'h01, 16'h0});
         send_move(2'd1, 6'd0, 6'd0, 6'd0, 6'd0);
         run_frame(1'b0);
      end
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
